// File: rtl/systolic_tile_scheduler.sv
// -----------------------------------------------------------------------------
// systolic_tile_scheduler
//
// Tile-level sequencer for the systolic array. Walks an M x K x N tiled matmul
// with m outermost, n in the middle and k innermost. For every k-tile it issues
// a weight (B) slice request and an activation (A) slice request, waits until
// the array reports both slices loaded, then fires one compute pass. After the
// last k-tile of an (m,n) output tile it issues one result-drain request.
//
// Ports
//   s_clk, s_rst_n                 clock (rising edge), async active-low reset
//   cfg_valid / cfg_ready          job descriptor handshake
//   cfg_m/k/n_tiles                tile counts, latched on descriptor accept
//   wgt_req_valid/ready, _k, _n    B-slice fetch request, payload (k,n)
//   act_req_valid/ready, _m, _k    A-slice fetch request, payload (m,k)
//   load_done                      pulse: array holds both slices
//   cal_start, cal_acc             pulse: start a compute pass; acc=0 clears psum
//   cal_done                       pulse: compute pass finished
//   out_req_valid/ready, _m, _n    drain request for a finished output tile
//   busy                           high in every state except IDLE
//   done                           pulse: job complete
//
// Every output comes straight from a register.
// -----------------------------------------------------------------------------
module systolic_tile_scheduler #(
    parameter int UNIT_NUM = 8,
    parameter int DIM_W    = 8
) (
    input  logic             s_clk,
    input  logic             s_rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIM_W-1:0] cfg_m_tiles,
    input  logic [DIM_W-1:0] cfg_k_tiles,
    input  logic [DIM_W-1:0] cfg_n_tiles,
    output logic             wgt_req_valid,
    input  logic             wgt_req_ready,
    output logic [DIM_W-1:0] wgt_req_k,
    output logic [DIM_W-1:0] wgt_req_n,
    output logic             act_req_valid,
    input  logic             act_req_ready,
    output logic [DIM_W-1:0] act_req_m,
    output logic [DIM_W-1:0] act_req_k,
    input  logic             load_done,
    output logic             cal_start,
    output logic             cal_acc,
    input  logic             cal_done,
    output logic             out_req_valid,
    input  logic             out_req_ready,
    output logic [DIM_W-1:0] out_req_m,
    output logic [DIM_W-1:0] out_req_n,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_LOAD = 3'd2,
        ST_CAL       = 3'd3,
        ST_WAIT_CAL  = 3'd4,
        ST_DRAIN     = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

    localparam logic [DIM_W-1:0] IDX_ZERO = {DIM_W{1'b0}};
    localparam logic [DIM_W-1:0] IDX_ONE  = {{(DIM_W-1){1'b0}}, 1'b1};

    state_e           state_r;
    logic [DIM_W-1:0] m_cnt_r, k_cnt_r, n_cnt_r;
    logic [DIM_W-1:0] m_r, k_r, n_r;
    logic             load_flag_r;
    logic             cfg_ready_r;
    logic             wgt_valid_r, act_valid_r, out_valid_r;
    logic [DIM_W-1:0] wgt_k_r, wgt_n_r, act_m_r, act_k_r, out_m_r, out_n_r;
    logic             cal_start_r, cal_acc_r, busy_r, done_r;

    logic k_last_s, n_last_s, m_last_s;
    logic cfg_zero_s, issue_done_s;

    // Last-index detection over the full index width (counts are >= 1 here)
    assign k_last_s   = (k_r == (k_cnt_r - IDX_ONE));
    assign n_last_s   = (n_r == (n_cnt_r - IDX_ONE));
    assign m_last_s   = (m_r == (m_cnt_r - IDX_ONE));
    assign cfg_zero_s = (cfg_m_tiles == IDX_ZERO) || (cfg_k_tiles == IDX_ZERO) ||
                        (cfg_n_tiles == IDX_ZERO);
    // True once every request still pending is being accepted this cycle
    assign issue_done_s = (!wgt_valid_r || wgt_req_ready) && (!act_valid_r || act_req_ready);

    // Job sequencer: state, loop indices, load flag and all registered outputs
    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_r     <= ST_IDLE;
            m_cnt_r     <= IDX_ZERO;
            k_cnt_r     <= IDX_ZERO;
            n_cnt_r     <= IDX_ZERO;
            m_r         <= IDX_ZERO;
            k_r         <= IDX_ZERO;
            n_r         <= IDX_ZERO;
            load_flag_r <= 1'b0;
            cfg_ready_r <= 1'b1;
            wgt_valid_r <= 1'b0;
            wgt_k_r     <= IDX_ZERO;
            wgt_n_r     <= IDX_ZERO;
            act_valid_r <= 1'b0;
            act_m_r     <= IDX_ZERO;
            act_k_r     <= IDX_ZERO;
            cal_start_r <= 1'b0;
            cal_acc_r   <= 1'b0;
            out_valid_r <= 1'b0;
            out_m_r     <= IDX_ZERO;
            out_n_r     <= IDX_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            // Pulse outputs default low; states below raise them for one cycle
            cal_start_r <= 1'b0;
            done_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cfg_valid && cfg_ready_r) begin
                        m_cnt_r     <= cfg_m_tiles;
                        k_cnt_r     <= cfg_k_tiles;
                        n_cnt_r     <= cfg_n_tiles;
                        m_r         <= IDX_ZERO;
                        k_r         <= IDX_ZERO;
                        n_r         <= IDX_ZERO;
                        load_flag_r <= 1'b0;
                        cfg_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        if (cfg_zero_s) begin
                            // Degenerate job: nothing to compute, report completion
                            state_r <= ST_DONE;
                        end else begin
                            state_r     <= ST_ISSUE;
                            wgt_valid_r <= 1'b1;
                            wgt_k_r     <= IDX_ZERO;
                            wgt_n_r     <= IDX_ZERO;
                            act_valid_r <= 1'b1;
                            act_m_r     <= IDX_ZERO;
                            act_k_r     <= IDX_ZERO;
                        end
                    end else begin
                        cfg_ready_r <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // load_done may land while requests are still in flight
                    if (load_done) begin
                        load_flag_r <= 1'b1;
                    end
                    if (wgt_valid_r && wgt_req_ready) begin
                        wgt_valid_r <= 1'b0;
                    end
                    if (act_valid_r && act_req_ready) begin
                        act_valid_r <= 1'b0;
                    end
                    if (issue_done_s) begin
                        state_r <= ST_WAIT_LOAD;
                    end
                end
                ST_WAIT_LOAD: begin
                    if (load_flag_r || load_done) begin
                        state_r     <= ST_CAL;
                        cal_start_r <= 1'b1;
                        cal_acc_r   <= (k_r != IDX_ZERO);
                        load_flag_r <= 1'b0;
                    end
                end
                ST_CAL: begin
                    state_r <= ST_WAIT_CAL;
                end
                ST_WAIT_CAL: begin
                    if (cal_done) begin
                        if (k_last_s) begin
                            k_r         <= IDX_ZERO;
                            state_r     <= ST_DRAIN;
                            out_valid_r <= 1'b1;
                            out_m_r     <= m_r;
                            out_n_r     <= n_r;
                        end else begin
                            k_r         <= k_r + IDX_ONE;
                            state_r     <= ST_ISSUE;
                            wgt_valid_r <= 1'b1;
                            wgt_k_r     <= k_r + IDX_ONE;
                            wgt_n_r     <= n_r;
                            act_valid_r <= 1'b1;
                            act_m_r     <= m_r;
                            act_k_r     <= k_r + IDX_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_req_ready) begin
                        out_valid_r <= 1'b0;
                        if (!n_last_s) begin
                            n_r         <= n_r + IDX_ONE;
                            state_r     <= ST_ISSUE;
                            wgt_valid_r <= 1'b1;
                            wgt_k_r     <= IDX_ZERO;
                            wgt_n_r     <= n_r + IDX_ONE;
                            act_valid_r <= 1'b1;
                            act_m_r     <= m_r;
                            act_k_r     <= IDX_ZERO;
                        end else begin
                            n_r <= IDX_ZERO;
                            if (!m_last_s) begin
                                m_r         <= m_r + IDX_ONE;
                                state_r     <= ST_ISSUE;
                                wgt_valid_r <= 1'b1;
                                wgt_k_r     <= IDX_ZERO;
                                wgt_n_r     <= IDX_ZERO;
                                act_valid_r <= 1'b1;
                                act_m_r     <= m_r + IDX_ONE;
                                act_k_r     <= IDX_ZERO;
                            end else begin
                                state_r <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle
                    state_r     <= ST_IDLE;
                    wgt_valid_r <= 1'b0;
                    act_valid_r <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    cfg_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready     = cfg_ready_r;
    assign wgt_req_valid = wgt_valid_r;
    assign wgt_req_k     = wgt_k_r;
    assign wgt_req_n     = wgt_n_r;
    assign act_req_valid = act_valid_r;
    assign act_req_m     = act_m_r;
    assign act_req_k     = act_k_r;
    assign cal_start     = cal_start_r;
    assign cal_acc       = cal_acc_r;
    assign out_req_valid = out_valid_r;
    assign out_req_m     = out_m_r;
    assign out_req_n     = out_n_r;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_systolic_tile_scheduler
//
// Directed bench for the tile scheduler. The job driver plays the fetchers,
// array and writeback, logging every cycle a request is valid plus each
// compute pass; the logs are then compared with hand-derived loop orders.
// -----------------------------------------------------------------------------
module tb_systolic_tile_scheduler;

    localparam int DW = 8;

    logic          s_clk = 1'b0;
    logic          s_rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [DW-1:0] cfg_m_tiles = 8'd0, cfg_k_tiles = 8'd0, cfg_n_tiles = 8'd0;
    logic          wgt_req_valid, act_req_valid, out_req_valid;
    logic          wgt_req_ready = 1'b1, act_req_ready = 1'b1, out_req_ready = 1'b1;
    logic [DW-1:0] wgt_req_k, wgt_req_n, act_req_m, act_req_k, out_req_m, out_req_n;
    logic          load_done = 1'b0, cal_done = 1'b0;
    logic          cal_start, cal_acc, busy, done;

    always #5 s_clk = ~s_clk;

    systolic_tile_scheduler #(.UNIT_NUM(8), .DIM_W(DW)) dut (
        .s_clk(s_clk), .s_rst_n(s_rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_m_tiles(cfg_m_tiles), .cfg_k_tiles(cfg_k_tiles), .cfg_n_tiles(cfg_n_tiles),
        .wgt_req_valid(wgt_req_valid), .wgt_req_ready(wgt_req_ready),
        .wgt_req_k(wgt_req_k), .wgt_req_n(wgt_req_n),
        .act_req_valid(act_req_valid), .act_req_ready(act_req_ready),
        .act_req_m(act_req_m), .act_req_k(act_req_k),
        .load_done(load_done), .cal_start(cal_start), .cal_acc(cal_acc), .cal_done(cal_done),
        .out_req_valid(out_req_valid), .out_req_ready(out_req_ready),
        .out_req_m(out_req_m), .out_req_n(out_req_n),
        .busy(busy), .done(done)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [2*DW-1:0] wq[$];   // {k,n} every cycle wgt_req_valid is high
    logic [2*DW-1:0] aq[$];   // {m,k} every cycle act_req_valid is high
    logic [2*DW-1:0] oq[$];   // {m,n} every cycle out_req_valid is high
    logic            cq[$];   // cal_acc at each cal_start
    int              dq[$];   // cycles from final request accept to cal_start
    int              done_cyc;
    int              ndone;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one job: ld_lat = cycles from final request accept to load_done,
    // cl_lat = cycles from cal_start to cal_done, w_stall/o_stall = number of
    // valid cycles with ready held low, abort_cal = return at that cal_start.
    task automatic run_job(input int mt, input int kt, input int nt, input int ld_lat,
                           input int cl_lat, input int w_stall, input int o_stall,
                           input int abort_cal, input int max_cyc);
        int  lt, ct, last_req, ws, os;
        bit  fin;
        wq.delete(); aq.delete(); oq.delete(); cq.delete(); dq.delete();
        ndone = 0; done_cyc = -1;
        lt = 0; ct = 0; last_req = -1; ws = w_stall; os = o_stall; fin = 1'b0;
        @(negedge s_clk);
        chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
        cfg_valid = 1'b1;
        cfg_m_tiles = DW'(mt); cfg_k_tiles = DW'(kt); cfg_n_tiles = DW'(nt);
        wgt_req_ready = 1'b1; act_req_ready = 1'b1; out_req_ready = 1'b1;
        for (int c = 1; c <= max_cyc && !fin; c++) begin
            @(negedge s_clk);
            cfg_valid = 1'b0; load_done = 1'b0; cal_done = 1'b0;
            if (c == 1) begin
                chk("cfg_ready_drop", {31'd0, cfg_ready}, 32'd0);
                chk("busy_rise", {31'd0, busy}, 32'd1);
            end
            wgt_req_ready = !(wgt_req_valid && ws > 0);
            if (wgt_req_valid) begin
                wq.push_back({wgt_req_k, wgt_req_n});
                if (ws > 0) ws--;
            end
            act_req_ready = 1'b1;
            if (act_req_valid) aq.push_back({act_req_m, act_req_k});
            if ((wgt_req_valid || act_req_valid) && !(wgt_req_valid && !wgt_req_ready)) begin
                last_req = c;
                if (ld_lat == 0) load_done = 1'b1;
                else lt = ld_lat;
            end else if (lt > 0) begin
                lt--;
                if (lt == 0) load_done = 1'b1;
            end
            if (cal_start) begin
                cq.push_back(cal_acc);
                dq.push_back(c - last_req);
                ct = cl_lat;
                if (cq.size() == abort_cal) fin = 1'b1;
            end else if (ct > 0) begin
                ct--;
                if (ct == 0) cal_done = 1'b1;
            end
            out_req_ready = !(out_req_valid && os > 0);
            if (out_req_valid) begin
                oq.push_back({out_req_m, out_req_n});
                if (os > 0) os--;
            end
            if (done) begin
                ndone++;
                done_cyc = c;
                fin = 1'b1;
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
        chk("job_finished_in_budget", {31'd0, fin}, 32'd1);
    endtask

    // Compares the logs of an unstalled job with the m/n/k loop order
    task automatic check_std(input int mt, input int kt, input int nt, input int exp_diff);
        int i, j;
        chk("wgt_count", wq.size(), mt * kt * nt);
        chk("act_count", aq.size(), mt * kt * nt);
        chk("cal_count", cq.size(), mt * kt * nt);
        chk("drain_count", oq.size(), mt * nt);
        chk("done_count", ndone, 1);
        i = 0; j = 0;
        for (int m = 0; m < mt; m++) begin
            for (int n = 0; n < nt; n++) begin
                for (int k = 0; k < kt; k++) begin
                    if (i < wq.size()) chk("wgt_kn", {16'd0, wq[i]}, {16'd0, DW'(k), DW'(n)});
                    if (i < aq.size()) chk("act_mk", {16'd0, aq[i]}, {16'd0, DW'(m), DW'(k)});
                    if (i < cq.size()) chk("cal_acc", {31'd0, cq[i]}, {31'd0, (k != 0)});
                    if (i < dq.size()) chk("load_to_cal", dq[i], exp_diff);
                    i++;
                end
                if (j < oq.size()) chk("drain_mn", {16'd0, oq[j]}, {16'd0, DW'(m), DW'(n)});
                j++;
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge s_clk);
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valids", {29'd0, wgt_req_valid, act_req_valid, out_req_valid}, 32'd0);
        chk("rst_pulses", {30'd0, cal_start, done}, 32'd0);
        chk("rst_indices", {wgt_req_k, wgt_req_n, act_req_m, out_req_n}, 32'd0);
        s_rst_n = 1'b1;

        // 1: single tile job
        run_job(1, 1, 1, 2, 10, 0, 0, 0, 200);
        check_std(1, 1, 1, 3);
        chk("t1_cfg_ready_in_done_cycle", {31'd0, cfg_ready}, 32'd0);
        @(negedge s_clk);
        chk("t1_cfg_ready_back", {31'd0, cfg_ready}, 32'd1);

        // 2: M=2 K=3 N=2 loop order and accumulate pattern
        run_job(2, 3, 2, 2, 10, 0, 0, 0, 1000);
        check_std(2, 3, 2, 3);

        // 3: weight fetcher stalls 5 cycles on the first k-tile (M=1 K=2 N=1)
        run_job(1, 2, 1, 2, 10, 5, 0, 0, 300);
        chk("t3_wgt_cycles", wq.size(), 7);
        for (int i = 0; i < 6; i++) begin
            if (i < wq.size()) chk("t3_wgt_held", {16'd0, wq[i]}, 32'h0000);
        end
        if (wq.size() > 6) chk("t3_wgt_k1", {16'd0, wq[6]}, 32'h0100);
        chk("t3_act_cycles", aq.size(), 2);
        if (aq.size() > 1) chk("t3_act_k1", {16'd0, aq[1]}, 32'h0001);
        chk("t3_cal_count", cq.size(), 2);
        if (dq.size() > 0) chk("t3_cal_after_wgt", dq[0], 3);
        chk("t3_done", ndone, 1);

        // 4: load_done in the final accept cycle -> cal_start 2 cycles later
        run_job(1, 2, 1, 0, 6, 0, 0, 0, 200);
        check_std(1, 2, 1, 2);

        // 5a: K=0 -> immediate completion
        run_job(4, 0, 4, 2, 10, 0, 0, 0, 50);
        chk("t5_no_wgt", wq.size(), 0);
        chk("t5_no_act", aq.size(), 0);
        chk("t5_no_cal", cq.size(), 0);
        chk("t5_no_drain", oq.size(), 0);
        chk("t5_done_latency", done_cyc, 2);

        // 5b: writeback stalls 3 cycles on the first drain (M=1 K=1 N=2)
        run_job(1, 1, 2, 2, 10, 0, 3, 0, 300);
        chk("t5b_drain_cycles", oq.size(), 5);
        for (int i = 0; i < 4; i++) begin
            if (i < oq.size()) chk("t5b_drain_held", {16'd0, oq[i]}, 32'h0000);
        end
        if (oq.size() > 4) chk("t5b_drain_next", {16'd0, oq[4]}, 32'h0001);
        chk("t5b_wgt_count", wq.size(), 2);
        if (wq.size() > 1) chk("t5b_wgt_n1", {16'd0, wq[1]}, 32'h0001);
        chk("t5b_done", ndone, 1);

        // 6: reset during WAIT_CAL of the test-2 job, then rerun test 1
        run_job(2, 3, 2, 2, 10, 0, 0, 5, 1000);
        chk("t6_fifth_cal", cq.size(), 5);
        @(posedge s_clk);
        #2;
        chk("t6_busy_before_rst", {31'd0, busy}, 32'd1);
        s_rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_valids", {29'd0, wgt_req_valid, act_req_valid, out_req_valid}, 32'd0);
        chk("t6_rst_pulses", {30'd0, cal_start, done}, 32'd0);
        chk("t6_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("t6_rst_wgt_idx", {16'd0, wgt_req_k, wgt_req_n}, 32'd0);
        @(negedge s_clk);
        s_rst_n = 1'b1;
        run_job(1, 1, 1, 2, 10, 0, 0, 0, 200);
        check_std(1, 1, 1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
